// File: rtl/sca_acq_sequencer_if.sv
// Run-control side of the SCA acquisition sequencer: command, configuration
// and status signals exchanged with the register bank.
interface sca_acq_sequencer_if;
    logic        start;
    logic        abort;
    logic        ext_trig;
    logic        cfg_ext_en;
    logic [10:0] cfg_trig_dly;
    logic [5:0]  cfg_trig_len;
    logic [7:0]  cfg_nclk;
    logic        busy;
    logic        done;
    logic [15:0] frame_cnt;

    modport master (
        output start, abort, ext_trig, cfg_ext_en, cfg_trig_dly, cfg_trig_len, cfg_nclk,
        input  busy, done, frame_cnt
    );

    modport slave (
        input  start, abort, ext_trig, cfg_ext_en, cfg_trig_dly, cfg_trig_len, cfg_nclk,
        output busy, done, frame_cnt
    );
endinterface

// File: rtl/sca_acq_sequencer.sv
// SCA acquisition sequencer: free-running clk_REF plus a one-shot FSM that
// drives start_pad/RN_DFF, trigger_pad, SR_DFF and the clk_DFF readout burst
// for each start command. Every pad and status output is a flop.
module sca_acq_sequencer #(
    parameter int REF_HALF = 16,
    parameter int DFF_HALF = 7,
    parameter int SR_LEN   = 13
) (
    input  logic               clk_125,
    input  logic               rst,
    sca_acq_sequencer_if.slave bus,
    output logic               clk_REF,
    output logic               start_pad,
    output logic               trigger_pad,
    output logic               RN_DFF,
    output logic               SR_DFF,
    output logic               clk_DFF
);
    localparam int               REF_W    = $clog2(2 * REF_HALF);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(2 * REF_HALF - 1);
    localparam logic [REF_W-1:0] REF_PRE  = REF_W'(REF_HALF - 1);
    localparam logic [REF_W-1:0] REF_MID  = REF_W'(REF_HALF);
    localparam logic [15:0]      SR_LOAD  = 16'(SR_LEN - 1);
    localparam logic [15:0]      DFF_LAST = 16'(DFF_HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARM       = 3'd1,
        S_WAIT_TRIG = 3'd2,
        S_TRIG      = 3'd3,
        S_SR        = 3'd4,
        S_READOUT   = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [REF_W-1:0] ref_cnt_r, ref_cnt_nxt_s;
    logic             clk_ref_r, clk_ref_nxt_s;
    logic [15:0]      cnt_r, cnt_nxt_s;
    logic [8:0]       half_r, half_nxt_s;
    logic             start_pad_r, start_pad_nxt_s;
    logic             trig_r, trig_nxt_s;
    logic             rn_r, rn_nxt_s;
    logic             sr_r, sr_nxt_s;
    logic             clk_dff_r, clk_dff_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             done_r, done_nxt_s;
    logic [15:0]      frame_cnt_r, frame_cnt_nxt_s;
    logic             sh_ext_r, sh_ext_nxt_s;
    logic [10:0]      sh_dly_r, sh_dly_nxt_s;
    logic [5:0]       sh_len_r, sh_len_nxt_s;
    logic [7:0]       sh_nclk_r, sh_nclk_nxt_s;
    logic [15:0]      ro_cnt_s;
    logic [8:0]       ro_half_s;
    logic             ro_clk_s;
    logic [8:0]       last_half_s;

    // Reference counter wrap and the clk_REF level that follows from it.
    always_comb begin
        if (ref_cnt_r == REF_LAST) begin
            ref_cnt_nxt_s = {REF_W{1'b0}};
        end else begin
            ref_cnt_nxt_s = ref_cnt_r + REF_W'(1);
        end
        clk_ref_nxt_s = (ref_cnt_nxt_s < REF_MID);
    end

    // Readout phase stepping: a half-period counter that toggles clk_DFF on wrap.
    // The FSM leaves READOUT one cycle before the final fall so that DONE
    // performs that fall together with done and the start_pad/RN_DFF release.
    always_comb begin
        last_half_s = {sh_nclk_r, 1'b0} - 9'd1;
        if (cnt_r == DFF_LAST) begin
            ro_cnt_s  = 16'd0;
            ro_half_s = half_r + 9'd1;
            ro_clk_s  = ~clk_dff_r;
        end else begin
            ro_cnt_s  = cnt_r + 16'd1;
            ro_half_s = half_r;
            ro_clk_s  = clk_dff_r;
        end
    end

    // Next-state and next-output logic of the acquisition FSM; abort wins over all.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        half_nxt_s      = half_r;
        start_pad_nxt_s = start_pad_r;
        trig_nxt_s      = trig_r;
        rn_nxt_s        = rn_r;
        sr_nxt_s        = sr_r;
        clk_dff_nxt_s   = clk_dff_r;
        done_nxt_s      = 1'b0;
        frame_cnt_nxt_s = frame_cnt_r;
        sh_ext_nxt_s    = sh_ext_r;
        sh_dly_nxt_s    = sh_dly_r;
        sh_len_nxt_s    = sh_len_r;
        sh_nclk_nxt_s   = sh_nclk_r;

        if ((state_r != S_IDLE) && bus.abort) begin
            state_nxt_s     = S_IDLE;
            start_pad_nxt_s = 1'b0;
            trig_nxt_s      = 1'b0;
            rn_nxt_s        = 1'b0;
            sr_nxt_s        = 1'b0;
            clk_dff_nxt_s   = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        sh_ext_nxt_s  = bus.cfg_ext_en;
                        sh_dly_nxt_s  = (bus.cfg_trig_dly == 11'd0) ? 11'd1 : bus.cfg_trig_dly;
                        sh_len_nxt_s  = (bus.cfg_trig_len == 6'd0) ? 6'd1 : bus.cfg_trig_len;
                        sh_nclk_nxt_s = bus.cfg_nclk;
                        state_nxt_s   = S_ARM;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end
                S_ARM: begin
                    if (ref_cnt_r == REF_PRE) begin
                        start_pad_nxt_s = 1'b1;
                        rn_nxt_s        = 1'b1;
                        cnt_nxt_s       = {5'd0, sh_dly_r} - 16'd1;
                        state_nxt_s     = S_WAIT_TRIG;
                    end else begin
                        state_nxt_s = S_ARM;
                    end
                end
                S_WAIT_TRIG: begin
                    if ((cnt_r == 16'd0) || (sh_ext_r && bus.ext_trig)) begin
                        trig_nxt_s  = 1'b1;
                        cnt_nxt_s   = {10'd0, sh_len_r} - 16'd1;
                        state_nxt_s = S_TRIG;
                    end else begin
                        cnt_nxt_s = cnt_r - 16'd1;
                    end
                end
                S_TRIG: begin
                    if (cnt_r == 16'd0) begin
                        trig_nxt_s  = 1'b0;
                        sr_nxt_s    = 1'b1;
                        cnt_nxt_s   = SR_LOAD;
                        state_nxt_s = S_SR;
                    end else begin
                        cnt_nxt_s = cnt_r - 16'd1;
                    end
                end
                S_SR: begin
                    if (cnt_r == 16'd0) begin
                        sr_nxt_s = 1'b0;
                        if (sh_nclk_r == 8'd0) begin
                            state_nxt_s = S_DONE;
                        end else begin
                            cnt_nxt_s     = 16'd0;
                            half_nxt_s    = 9'd0;
                            clk_dff_nxt_s = 1'b0;
                            state_nxt_s   = S_READOUT;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r - 16'd1;
                    end
                end
                S_READOUT: begin
                    cnt_nxt_s     = ro_cnt_s;
                    half_nxt_s    = ro_half_s;
                    clk_dff_nxt_s = ro_clk_s;
                    if ((ro_half_s == last_half_s) && (ro_cnt_s == DFF_LAST)) begin
                        state_nxt_s = S_DONE;
                    end else begin
                        state_nxt_s = S_READOUT;
                    end
                end
                S_DONE: begin
                    done_nxt_s      = 1'b1;
                    start_pad_nxt_s = 1'b0;
                    rn_nxt_s        = 1'b0;
                    clk_dff_nxt_s   = 1'b0;
                    frame_cnt_nxt_s = frame_cnt_r + 16'd1;
                    state_nxt_s     = S_IDLE;
                end
                default: begin
                    state_nxt_s     = S_IDLE;
                    start_pad_nxt_s = 1'b0;
                    trig_nxt_s      = 1'b0;
                    rn_nxt_s        = 1'b0;
                    sr_nxt_s        = 1'b0;
                    clk_dff_nxt_s   = 1'b0;
                end
            endcase
        end
        busy_nxt_s = (state_nxt_s != S_IDLE);
    end

    // State, counters, shadow configuration and all output flops.
    always_ff @(posedge clk_125 or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            ref_cnt_r   <= {REF_W{1'b0}};
            clk_ref_r   <= 1'b1;
            cnt_r       <= 16'd0;
            half_r      <= 9'd0;
            start_pad_r <= 1'b0;
            trig_r      <= 1'b0;
            rn_r        <= 1'b0;
            sr_r        <= 1'b0;
            clk_dff_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            frame_cnt_r <= 16'd0;
            sh_ext_r    <= 1'b0;
            sh_dly_r    <= 11'd0;
            sh_len_r    <= 6'd0;
            sh_nclk_r   <= 8'd0;
        end else begin
            state_r     <= state_nxt_s;
            ref_cnt_r   <= ref_cnt_nxt_s;
            clk_ref_r   <= clk_ref_nxt_s;
            cnt_r       <= cnt_nxt_s;
            half_r      <= half_nxt_s;
            start_pad_r <= start_pad_nxt_s;
            trig_r      <= trig_nxt_s;
            rn_r        <= rn_nxt_s;
            sr_r        <= sr_nxt_s;
            clk_dff_r   <= clk_dff_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            frame_cnt_r <= frame_cnt_nxt_s;
            sh_ext_r    <= sh_ext_nxt_s;
            sh_dly_r    <= sh_dly_nxt_s;
            sh_len_r    <= sh_len_nxt_s;
            sh_nclk_r   <= sh_nclk_nxt_s;
        end
    end

    assign clk_REF       = clk_ref_r;
    assign start_pad     = start_pad_r;
    assign trigger_pad   = trig_r;
    assign RN_DFF        = rn_r;
    assign SR_DFF        = sr_r;
    assign clk_DFF       = clk_dff_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.frame_cnt = frame_cnt_r;
endmodule
